robo_scene_core: RTL and testbench
==================================

// Module: robo_scene_core
// PURPOSE
//  Per-pixel scene lookup and timing core for the ROBO-ESCAPE renderer. Provides the
//  rate-tick generator, the static platform map (background) lookup and the robot
//  sprite lookup. Sits between the raster scanner and the colour mux/movement logic.
//  Has a second background port so movement logic can run collision probes.
// PARAMETERS
//  CLK_HZ  50_000_000  input clock frequency in Hz; must be > 255
// PORTS
//  clock        in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high
//  rate         in   8  tick frequency in Hz (0 = never tick)
//  tick         out  1  one-cycle pulse, rate pulses per CLK_HZ cycles
//  pix_x        in   9  raster x coordinate (0..319 on screen)
//  pix_y        in   9  raster y coordinate (0..239 on screen)
//  char_x       in   9  sprite top-left x
//  char_y       in   9  sprite top-left y
//  bg_colour    out  3  background colour at (pix_x,pix_y); 000 = empty
//  char_colour  out  3  sprite colour at (pix_x,pix_y); 111 = transparent
//  probe_x      in   9  collision probe x
//  probe_y      in   9  collision probe y
//  probe_bg     out  3  background colour at (probe_x,probe_y); 000 = free
// BEHAVIOUR
//  Reset: tick=0, accumulator=0, bg_colour=000, probe_bg=000, char_colour=111.
//  Tick generator, phase accumulator acc (width ceil(log2(CLK_HZ+256))):
//  - Each edge: if acc+rate >= CLK_HZ then acc<=acc+rate-CLK_HZ and tick<=1,
//    else acc<=acc+rate and tick<=0. Exactly rate ticks per CLK_HZ cycles.
//  - Invariant acc<CLK_HZ. A rate change takes effect on the next edge; acc is kept.
//  Background map: all lookups are registered, 1-cycle latency, same map on both ports.
//  - x>=320 or y>=240 -> 000.
//  - Colour 010 (platform) for: floor y 225..239; left wall x 0..7; right wall x 312..319;
//    platform A x 60..139, y 180..187; B x 180..259, y 140..147; C x 100..179, y 100..107.
//  - All other on-screen pixels -> 000. Ranges are inclusive.
//  Sprite lookup (registered, 1-cycle latency):
//  - dx=pix_x-char_x, dy=pix_y-char_y, each mod 512 (9-bit wrap).
//  - Inside the box iff dx<8 and dy<12; outside the box -> 111.
//  - Rows 0..3: cols 2..5 -> 110 (head). Rows 4..8: cols 0..7 -> 100 (body).
//  - Rows 9..11: cols 1,2,5,6 -> 001 (legs). Other in-box pixels -> 111.
//  - The 9-bit wrap means a sprite near x=511 wraps to column 0; no clipping is done.
//  Reset asserted mid-operation overrides all other logic on that edge.
//  No handshakes; inputs are sampled on every edge.
// TESTING
//  Test CLK_HZ=10, rate=3, reset released: tick high after edges 4, 7, 10, 14 -> 3 per 10.
//  Test CLK_HZ=10, rate=0 for 50 cycles -> tick never high; rate=10 -> tick every cycle.
//  Background at (0,100),(319,0),(150,230),(60,180),(139,187),(200,145),(100,100): 010, one cycle later.
//  Background at (59,180),(140,184),(150,120),(320,230),(10,240): 000.
//  Probe port at (150,230) with pix at (150,120) in the same cycle -> probe_bg=010, bg_colour=000.
//  Sprite with char=(35,205): (37,205)=110, (35,210)=100, (36,215)=001, (35,205)=111, (43,205)=111, (35,217)=111.
//  Sprite with char=(0,0): (511,0)=111, no wrap artefact.
//  Assert reset while rate=10: next edge tick=0, char_colour=111, bg_colour=000.
//  Release reset: first tick arrives after a full period.

Source files
------------

// File: rtl/robo_scene_core.sv
// Scene lookup and timing core: rate-tick phase accumulator, static platform map with a
// second collision-probe port, and the robot sprite lookup. All outputs are registered.
module robo_scene_core #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rate,
    output logic       tick,
    input  logic [8:0] pix_x,
    input  logic [8:0] pix_y,
    input  logic [8:0] char_x,
    input  logic [8:0] char_y,
    output logic [2:0] bg_colour,
    output logic [2:0] char_colour,
    input  logic [8:0] probe_x,
    input  logic [8:0] probe_y,
    output logic [2:0] probe_bg
);

    // acc stays below CLK_HZ, so acc + rate always fits without an extra carry bit
    localparam int ACC_W = $clog2(CLK_HZ + 256);
    localparam logic [ACC_W-1:0] HZ = ACC_W'(CLK_HZ);

    localparam logic [2:0] EMPTY       = 3'b000;
    localparam logic [2:0] PLATFORM    = 3'b010;
    localparam logic [2:0] HEAD        = 3'b110;
    localparam logic [2:0] BODY        = 3'b100;
    localparam logic [2:0] LEGS        = 3'b001;
    localparam logic [2:0] TRANSPARENT = 3'b111;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc + ACC_W'(rate);

    function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo,
                                      input logic [8:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [2:0] bg_lookup(input logic [8:0] x, input logic [8:0] y);
        logic hit;
        hit = (y >= 9'd225)
            || (x <= 9'd7)
            || (x >= 9'd312)
            || (in_range(x, 9'd60,  9'd139) && in_range(y, 9'd180, 9'd187))
            || (in_range(x, 9'd180, 9'd259) && in_range(y, 9'd140, 9'd147))
            || (in_range(x, 9'd100, 9'd179) && in_range(y, 9'd100, 9'd107));
        if (x >= 9'd320 || y >= 9'd240) begin
            return EMPTY;
        end
        return hit ? PLATFORM : EMPTY;
    endfunction

    // Offsets wrap modulo 512, so a sprite near the right edge continues at column 0
    function automatic logic [2:0] sprite_lookup(input logic [8:0] px, input logic [8:0] py,
                                                 input logic [8:0] cx, input logic [8:0] cy);
        logic [8:0] dx;
        logic [8:0] dy;
        logic [2:0] colour;
        dx = px - cx;
        dy = py - cy;
        colour = TRANSPARENT;
        if (dx < 9'd8 && dy < 9'd12) begin
            if (dy < 9'd4) begin
                if (dx >= 9'd2 && dx <= 9'd5) colour = HEAD;
            end else if (dy < 9'd9) begin
                colour = BODY;
            end else begin
                if (dx == 9'd1 || dx == 9'd2 || dx == 9'd5 || dx == 9'd6) colour = LEGS;
            end
        end
        return colour;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            acc         <= '0;
            tick        <= 1'b0;
            bg_colour   <= EMPTY;
            probe_bg    <= EMPTY;
            char_colour <= TRANSPARENT;
        end else begin
            if (acc_sum >= HZ) begin
                acc  <= acc_sum - HZ;
                tick <= 1'b1;
            end else begin
                acc  <= acc_sum;
                tick <= 1'b0;
            end
            bg_colour   <= bg_lookup(pix_x, pix_y);
            probe_bg    <= bg_lookup(probe_x, probe_y);
            char_colour <= sprite_lookup(pix_x, pix_y, char_x, char_y);
        end
    end

endmodule

// File: tb/tb_robo_scene_core.sv
// Bench for robo_scene_core at CLK_HZ=10: directed scene/tick points followed by random
// stimulus, all checked against a cumulative-phase tick model and rectangle/sprite tables.
module tb_robo_scene_core;

    localparam int HZ = 10;

    logic       clock;
    logic       reset;
    logic [7:0] rate;
    logic       tick;
    logic [8:0] pix_x, pix_y, char_x, char_y, probe_x, probe_y;
    logic [2:0] bg_colour, char_colour, probe_bg;

    int  tests;
    int  fails;
    longint phase_total;
    logic       exp_tick;
    logic [2:0] exp_bg, exp_char, exp_probe;

    robo_scene_core #(.CLK_HZ(HZ)) dut (
        .clock(clock), .reset(reset), .rate(rate), .tick(tick),
        .pix_x(pix_x), .pix_y(pix_y), .char_x(char_x), .char_y(char_y),
        .bg_colour(bg_colour), .char_colour(char_colour),
        .probe_x(probe_x), .probe_y(probe_y), .probe_bg(probe_bg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Platform rectangles as {x0, x1, y0, y1}, inclusive
    int rects [6][4] = '{
        '{0, 319, 225, 239}, '{0, 7, 0, 239}, '{312, 319, 0, 239},
        '{60, 139, 180, 187}, '{180, 259, 140, 147}, '{100, 179, 100, 107}
    };

    function automatic logic [2:0] bg_model(int x, int y);
        if (x >= 320 || y >= 240) return 3'b000;
        for (int r = 0; r < 6; r++) begin
            if (x >= rects[r][0] && x <= rects[r][1] && y >= rects[r][2] && y <= rects[r][3])
                return 3'b010;
        end
        return 3'b000;
    endfunction

    function automatic logic [2:0] sprite_model(int px, int py, int cx, int cy);
        int dx;
        int dy;
        dx = (px - cx + 512) % 512;
        dy = (py - cy + 512) % 512;
        if (dx >= 8 || dy >= 12) return 3'b111;
        if (dy <= 3) return (dx >= 2 && dx <= 5) ? 3'b110 : 3'b111;
        if (dy <= 8) return 3'b100;
        return (dx == 1 || dx == 2 || dx == 5 || dx == 6) ? 3'b001 : 3'b111;
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] observed,
                               input logic [2:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, predicts the registered outputs and checks them after the edge
    task automatic applyStimulus(input logic rst, input int r, input int px, input int py,
                                 input int cx, input int cy, input int qx, input int qy);
        reset   = rst;
        rate    = 8'(r);
        pix_x   = 9'(px);
        pix_y   = 9'(py);
        char_x  = 9'(cx);
        char_y  = 9'(cy);
        probe_x = 9'(qx);
        probe_y = 9'(qy);
        if (rst) begin
            phase_total = 0;
            exp_tick  = 1'b0;
            exp_bg    = 3'b000;
            exp_probe = 3'b000;
            exp_char  = 3'b111;
        end else begin
            exp_tick = ((phase_total + r) / HZ) != (phase_total / HZ);
            phase_total = phase_total + r;
            exp_bg    = bg_model(px, py);
            exp_probe = bg_model(qx, qy);
            exp_char  = sprite_model(px, py, cx, cy);
        end
        @(posedge clock);
        #1;
        checkOutput("tick", {2'b00, tick}, {2'b00, exp_tick});
        checkOutput("bg_colour", bg_colour, exp_bg);
        checkOutput("probe_bg", probe_bg, exp_probe);
        checkOutput("char_colour", char_colour, exp_char);
    endtask

    int bg_on [7][2]  = '{'{0,100}, '{319,0}, '{150,230}, '{60,180}, '{139,187}, '{200,145}, '{100,100}};
    int bg_off [5][2] = '{'{59,180}, '{140,184}, '{150,120}, '{320,230}, '{10,240}};
    int spr [6][3]    = '{'{37,205,6}, '{35,210,4}, '{36,215,1}, '{35,205,7}, '{43,205,7}, '{35,217,7}};

    initial begin
        int tick_edges;
        int px, py, cx, cy;
        tests = 0;
        fails = 0;
        phase_total = 0;

        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_tick", {2'b00, tick}, 3'b000);
        checkOutput("reset_char", char_colour, 3'b111);

        // rate=3: ticks after edges 4, 7, 10 and 14
        tick_edges = 0;
        for (int e = 1; e <= 14; e++) begin
            applyStimulus(1'b0, 3, 400, 400, 0, 0, 400, 400);
            checkOutput("tick_rate3", {2'b00, tick},
                        (e == 4 || e == 7 || e == 10 || e == 14) ? 3'b001 : 3'b000);
            if (e <= 10 && tick) tick_edges++;
        end
        checkOutput("ticks_per_10", 3'(tick_edges), 3'd3);

        for (int e = 0; e < 50; e++) begin
            applyStimulus(1'b0, 0, 400, 400, 0, 0, 400, 400);
            checkOutput("tick_rate0", {2'b00, tick}, 3'b000);
        end
        for (int e = 0; e < 5; e++) begin
            applyStimulus(1'b0, 10, 400, 400, 0, 0, 400, 400);
            checkOutput("tick_rate10", {2'b00, tick}, 3'b001);
        end

        foreach (bg_on[i]) begin
            applyStimulus(1'b0, 0, bg_on[i][0], bg_on[i][1], 0, 0, 0, 0);
            checkOutput("bg_platform", bg_colour, 3'b010);
        end
        foreach (bg_off[i]) begin
            applyStimulus(1'b0, 0, bg_off[i][0], bg_off[i][1], 0, 0, 0, 0);
            checkOutput("bg_empty", bg_colour, 3'b000);
        end

        applyStimulus(1'b0, 0, 150, 120, 0, 0, 150, 230);
        checkOutput("probe_split_probe", probe_bg, 3'b010);
        checkOutput("probe_split_bg", bg_colour, 3'b000);

        foreach (spr[i]) begin
            applyStimulus(1'b0, 0, spr[i][0], spr[i][1], 35, 205, 0, 0);
            checkOutput("sprite_point", char_colour, 3'(spr[i][2]));
        end
        applyStimulus(1'b0, 0, 511, 0, 0, 0, 0, 0);
        checkOutput("sprite_no_wrap", char_colour, 3'b111);

        // Random stimulus with the sprite placed near the pixel so all regions are hit
        for (int n = 0; n < 400; n++) begin
            px = (n % 3 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 330);
            py = (n % 3 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 250);
            cx = (px - $urandom_range(0, 9) + 512) % 512;
            cy = (py - $urandom_range(0, 13) + 512) % 512;
            applyStimulus(1'b0, $urandom_range(0, 10), px, py, cx, cy,
                          $urandom_range(0, 330), $urandom_range(0, 250));
        end

        applyStimulus(1'b1, 10, 150, 230, 35, 205, 150, 230);
        checkOutput("midreset_tick", {2'b00, tick}, 3'b000);
        checkOutput("midreset_char", char_colour, 3'b111);
        checkOutput("midreset_bg", bg_colour, 3'b000);

        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1'b0, 3, 0, 0, 0, 0, 0, 0);
            checkOutput("post_reset_tick", {2'b00, tick}, (e == 4) ? 3'b001 : 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
